// File: rtl/fifo_addr_ctrl_pkg.sv
// Shared parameter package for the NTT/INTT butterfly delay-FIFO address
// controller, its FIFO-control interface and every client of that interface.
// Optional feature macro used by the importing files: FIFO_CTRL_WRAP_EN.
package fifo_addr_ctrl_pkg;

  localparam int NTT_STAGE_CNT = 8;
  localparam int MUL_STAGE_CNT = 4;

  // Depth of the largest butterfly delay FIFO (stage 0).
  function automatic int max_hrs_of(int ntt_stage_cnt);
    return 1 << (ntt_stage_cnt - 2);
  endfunction

  // Pointer width wide enough for the largest stage FIFO or the multiplier FIFO.
  function automatic int addr_bits_of(int ntt_stage_cnt, int mul_stage_cnt);
    int m;
    m = max_hrs_of(ntt_stage_cnt);
    if (mul_stage_cnt > m) m = mul_stage_cnt;
    return $clog2(m);
  endfunction

  // Delay depth of stage i; the last two stages collapse to a single entry.
  function automatic int stage_depth_of(int ntt_stage_cnt, int i);
    if (i >= ntt_stage_cnt - 2) return 1;
    return 1 << (ntt_stage_cnt - 2 - i);
  endfunction

  localparam int MAX_HRS             = max_hrs_of(NTT_STAGE_CNT);
  localparam int MAX_FIFO2_ADDR_BITS = addr_bits_of(NTT_STAGE_CNT, MUL_STAGE_CNT);

  // Stage depth for the package-default configuration.
  function automatic int stage_depth(int i);
    return stage_depth_of(NTT_STAGE_CNT, i);
  endfunction

endpackage

// File: rtl/fifo_addr_ctrl_mod_counter.sv
// Modulo-MODULUS pointer with synchronous clear and an optional registered
// wrap pulse (present only when FIFO_CTRL_WRAP_EN is defined).
module mod_counter #(
  parameter int MODULUS = 2,
  parameter int WIDTH   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
`ifdef FIFO_CTRL_WRAP_EN
  ,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic at_last;
  assign at_last = (cnt == LAST);

  // Advance on inc, fold back to zero after the last slot; clr beats inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_last ? '0 : cnt + WIDTH'(1);
    end
  end

`ifdef FIFO_CTRL_WRAP_EN
  // One-cycle pulse after the pointer folds from its last slot back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= !clr && inc && at_last;
    end
  end
`endif

endmodule

// File: rtl/fifo_addr_ctrl.sv
// Shared address generator for the NTT/INTT butterfly delay FIFOs: one
// independent modulo pointer per stage plus the multiplier-delay pointer.
// Optional feature macro: FIFO_CTRL_WRAP_EN adds the per-stage wrap pulses.
module fifo_addr_ctrl
  import fifo_addr_ctrl_pkg::*;
#(
  parameter int NTT_STAGE_CNT = fifo_addr_ctrl_pkg::NTT_STAGE_CNT,
  parameter int MUL_STAGE_CNT = fifo_addr_ctrl_pkg::MUL_STAGE_CNT,
  localparam int F2_BITS      = addr_bits_of(NTT_STAGE_CNT, MUL_STAGE_CNT),
  localparam int FM_BITS      = $clog2(MUL_STAGE_CNT - 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clr,
  input  logic [NTT_STAGE_CNT-1:0]              en,
  output logic [FM_BITS-1:0]                    fifom_addr,
  output logic [NTT_STAGE_CNT-1:0][F2_BITS-1:0] fifo2_addr
`ifdef FIFO_CTRL_WRAP_EN
  ,
  output logic [NTT_STAGE_CNT-1:0]              wrap
`endif
);

  logic any_en;
  assign any_en = |en;

  // Multiplier-delay pointer moves whenever any stage touches its FIFO.
`ifdef FIFO_CTRL_WRAP_EN
  logic fifom_wrap_unused;
`endif

  mod_counter #(
    .MODULUS(MUL_STAGE_CNT - 1),
    .WIDTH  (FM_BITS)
  ) u_mul_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (any_en),
    .cnt  (fifom_addr)
`ifdef FIFO_CTRL_WRAP_EN
    ,
    .wrap (fifom_wrap_unused)
`endif
  );

  // One fully independent pointer per butterfly stage.
  for (genvar i = 0; i < NTT_STAGE_CNT; i++) begin : g_stage
    mod_counter #(
      .MODULUS(stage_depth_of(NTT_STAGE_CNT, i)),
      .WIDTH  (F2_BITS)
    ) u_stage_ptr (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .inc  (en[i]),
      .cnt  (fifo2_addr[i])
`ifdef FIFO_CTRL_WRAP_EN
      ,
      .wrap (wrap[i])
`endif
    );
  end

endmodule

// File: tb/tb_fifo_addr_ctrl.sv
// Self-checking bench for fifo_addr_ctrl (NTT_STAGE_CNT=8, MUL_STAGE_CNT=4).
// Wrap checks are compiled in only when FIFO_CTRL_WRAP_EN is defined.
module tb_fifo_addr_ctrl;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int AB = 6;
  localparam int MB = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 clr = 1'b0;
  logic [N-1:0]         en = '0;
  logic [MB-1:0]        fifom_addr;
  logic [N-1:0][AB-1:0] fifo2_addr;
`ifdef FIFO_CTRL_WRAP_EN
  logic [N-1:0]         wrap;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  bit compare_on = 1'b0;

  int ptr_m [N];
  int mptr_m;
  bit wrap_m [N];

  fifo_addr_ctrl #(
    .NTT_STAGE_CNT(N),
    .MUL_STAGE_CNT(M)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .fifom_addr(fifom_addr),
    .fifo2_addr(fifo2_addr)
`ifdef FIFO_CTRL_WRAP_EN
    ,
    .wrap      (wrap)
`endif
  );

  always #5 clk = ~clk;

  // Stage depth straight from the rule max(1, 2^(N-2-i)).
  function automatic int depth_of(int i);
    int e;
    e = N - 2 - i;
    return (e < 0) ? 1 : (1 << e);
  endfunction

  // Reference model: plain modular arithmetic per stage, reset asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ptr_m[i] = 0;
        wrap_m[i] = 1'b0;
      end
      mptr_m = 0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) begin
        ptr_m[i] = 0;
        wrap_m[i] = 1'b0;
      end
      mptr_m = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        wrap_m[i] = en[i] && (ptr_m[i] == depth_of(i) - 1);
        if (en[i]) ptr_m[i] = (ptr_m[i] + 1) % depth_of(i);
      end
      if (en != 0) mptr_m = (mptr_m + 1) % (M - 1);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (compare_on) begin
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("model fifo2_addr[%0d]", i), int'(fifo2_addr[i]), ptr_m[i]);
`ifdef FIFO_CTRL_WRAP_EN
        checkOutput($sformatf("model wrap[%0d]", i), int'(wrap[i]), int'(wrap_m[i]));
`endif
      end
      checkOutput("model fifom_addr", int'(fifom_addr), mptr_m);
    end
  end

  // Drive one cycle of inputs, then let the edge land and settle.
  task automatic applyStimulus(input logic [N-1:0] en_v, input logic clr_v);
    en = en_v;
    clr = clr_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_on = 1'b1;

    // Reset state then idle
    for (int k = 0; k < 10; k++) applyStimulus('0, 1'b0);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("idle fifo2_addr[%0d]", i), int'(fifo2_addr[i]), 0);
    checkOutput("idle fifom_addr", int'(fifom_addr), 0);

    // Stage 0 for 65 consecutive cycles
    for (int k = 0; k < 65; k++) begin
      applyStimulus(8'b0000_0001, 1'b0);
      checkOutput("stage0 step", int'(fifo2_addr[0]), (k + 1) % 64);
      checkOutput("stage0 fifom", int'(fifom_addr), (k + 1) % 3);
`ifdef FIFO_CTRL_WRAP_EN
      checkOutput("stage0 wrap", int'(wrap[0]), (k == 63) ? 1 : 0);
`endif
    end
    checkOutput("stage0 after 65", int'(fifo2_addr[0]), 1);

    // Depth-1 stage: pointer pinned at zero
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'b0100_0000, 1'b0);
      checkOutput("stage6 pinned", int'(fifo2_addr[6]), 0);
`ifdef FIFO_CTRL_WRAP_EN
      checkOutput("stage6 wrap", int'(wrap[6]), 1);
`endif
    end
    applyStimulus('0, 1'b1);
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput("stage7 moves fifom", int'(fifom_addr), 1);
    checkOutput("stage7 pinned", int'(fifo2_addr[7]), 0);

    // Clear wins over a concurrent enable
    for (int k = 0; k < 10; k++) applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("stage2 at 10", int'(fifo2_addr[2]), 10);
    applyStimulus(8'b0000_0100, 1'b1);
    checkOutput("clr stage2", int'(fifo2_addr[2]), 0);
    checkOutput("clr fifom", int'(fifom_addr), 0);
    checkOutput("clr stage0", int'(fifo2_addr[0]), 0);

    // Sparse enable pattern on stage 1
    applyStimulus(8'b0000_0010, 1'b0);
    checkOutput("stage1 pat0", int'(fifo2_addr[1]), 1);
    applyStimulus(8'b0000_0000, 1'b0);
    checkOutput("stage1 pat1", int'(fifo2_addr[1]), 1);
    applyStimulus(8'b0000_0010, 1'b0);
    checkOutput("stage1 pat2", int'(fifo2_addr[1]), 2);
    applyStimulus(8'b0000_0010, 1'b0);
    checkOutput("stage1 pat3", int'(fifo2_addr[1]), 3);

    // Asynchronous reset in mid-cycle with pointers non-zero
    applyStimulus(8'b0000_0001, 1'b0);
    en = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst stage0", int'(fifo2_addr[0]), 0);
    checkOutput("async rst stage1", int'(fifo2_addr[1]), 0);
    checkOutput("async rst fifom", int'(fifom_addr), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'b0000_0001, 1'b0);
    checkOutput("post rst stage0", int'(fifo2_addr[0]), 1);

    // Randomized traffic with occasional clears
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] r_en;
      r_en = N'($urandom);
      if ($urandom_range(0, 3) == 0) r_en = '1;
      applyStimulus(r_en, ($urandom_range(0, 49) == 0));
    end

    applyStimulus('0, 1'b0);
    compare_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
